// File: rtl/sp_ram_fifo_pkg.sv
// rtl/sp_ram_fifo_pkg.sv - shared sizing constants for the single-port RAM FIFO
package sp_ram_fifo_pkg;
  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 32;
  localparam int LEVEL_W = ADDR_W + 1;
endpackage

// File: rtl/sp_ram_wf.sv
// rtl/sp_ram_wf.sv - 32x4 single-port write-first RAM, registered address, combinational read data
//
// Ports:
//   clk  - clock
//   en   - access enable; latches addr for the read path
//   we   - write enable (qualified by en)
//   addr - word address
//   di   - write data
//   dout - data at the address latched on the last enabled access
//
// Because the read path uses the registered address, a write leaves the new
// word visible on dout in the following cycle (write-first behaviour).
module sp_ram_wf
  import sp_ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (en) begin
      addr_d = addr;
    end
  end

  // No reset: contents persist across controller reset but become unreachable.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    if (en && we) begin
      mem_q[addr] <= di;
    end
  end

  assign dout = mem_q[addr_q];

endmodule

// File: rtl/sp_ram_fifo.sv
// rtl/sp_ram_fifo.sv - FIFO controller owning the single port of a 32x4 RAM
//
// Ports:
//   clk       - clock, all logic on rising edge
//   rst       - synchronous active-high reset
//   in_valid  - producer word available
//   in_data   - producer word
//   in_ready  - word accepted at edge when in_valid && in_ready
//   out_valid - out_data holds the FIFO head
//   out_data  - registered head word
//   out_ready - consumer takes the head at edge when out_valid && out_ready
//   level     - words held: RAM count + read in flight + output register
//
// Each cycle the single RAM port serves either a head prefetch read or a
// producer write, reads first. A read issued in cycle n returns data in
// cycle n+1 (rd_pend) and is captured into the output register at the end
// of that cycle.
module sp_ram_fifo
  import sp_ram_fifo_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [LEVEL_W-1:0] FULL_CNT = LEVEL_W'(DEPTH);

  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] ram_cnt_q, ram_cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  logic               rd_issue;
  logic               wr_acc;
  logic               pop;
  logic               ram_en;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_dout;

  // Prefetch only when the output stage will be free by the time data lands.
  // While rd_pend is set out_valid is always low, so capture never meets a pop.
  assign rd_issue = !rst && (ram_cnt_q != '0) && !rd_pend_q && (!out_valid_q || out_ready);
  assign in_ready = !rst && !rd_issue && (ram_cnt_q != FULL_CNT);
  assign wr_acc   = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;

  assign ram_en   = rd_issue || wr_acc;
  assign ram_addr = rd_issue ? rd_ptr_q : wr_ptr_q;

  sp_ram_wf u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (wr_acc),
    .addr (ram_addr),
    .di   (in_data),
    .dout (ram_dout)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    rd_pend_d   = rd_issue;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (wr_acc) begin
      wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
      ram_cnt_d = ram_cnt_q + LEVEL_W'(1);
    end
    if (rd_issue) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      ram_cnt_d = ram_cnt_q - LEVEL_W'(1);
    end

    if (rd_pend_q) begin
      out_data_d  = ram_dout;
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = ram_cnt_q + LEVEL_W'(rd_pend_q) + LEVEL_W'(out_valid_q);

endmodule
